// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline definitions for the processor datapath.
//   - Field widths of the EX/MEM stage (opcode, destination field, data).
//   - OPC_NOP: opcode value that marks a pipeline bubble.
//   - ex_mem_t: packed bundle of the four EX/MEM fields, stored as one
//     vector so that every field is always updated together.
package pipe_pkg;

    localparam int OPCODE_W = 5;
    localparam int RD_W     = 9;
    localparam int DATA_W   = 32;

    localparam logic [OPCODE_W-1:0] OPC_NOP = 5'd0;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [RD_W-1:0]     rd;
        logic [DATA_W-1:0]   branch_result;
        logic [DATA_W-1:0]   alu_result;
    } ex_mem_t;

    localparam int EX_MEM_W = $bits(ex_mem_t);

endpackage : pipe_pkg

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic pipeline-stage register.
//   clk : rising-edge clock
//   clr : synchronous clear (highest priority), loads all zeros
//   en  : load enable; when low the register holds its contents
//   d   : next-stage data in
//   q   : registered data out
module pipe_stage_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_r;

    // Stage storage: clear beats enable, hold when not enabled.
    always_ff @(posedge clk) begin
        if (clr) begin
            data_r <= {WIDTH{1'b0}};
        end else if (en) begin
            data_r <= d;
        end else begin
            data_r <= data_r;
        end
    end

    assign q = data_r;

endmodule : pipe_stage_reg

// File: rtl/reg_ex_mem.sv
// reg_ex_mem: EX/MEM pipeline register. Captures the execute-stage opcode,
// destination field, branch target and ALU result on every rising clk edge
// and presents them to the memory stage for one cycle. Pure storage.
//
// Optional feature macro: REGEXMEM_HAZARD_EN
//   defined   : stall (hold) and flush (load bubble) ports exist.
//               Priority per edge: rst > flush > stall > load.
//   undefined : no stall/flush ports; the register loads every cycle
//               unless rst is high.
//
// Ports:
//   clk             : clock, all state changes on rising edge
//   rst             : synchronous active-high reset, zeros all outputs
//   stall           : hold contents (REGEXMEM_HAZARD_EN only)
//   flush           : load all-zero bubble (REGEXMEM_HAZARD_EN only)
//   OpCode          : EX-stage opcode
//   RdOut           : EX-stage destination-register field
//   BranchResult    : EX-stage branch target
//   AluResult       : EX-stage ALU result
//   OpCodeOut, RdOutOut, BranchResultOut, AluResultOut : registered copies
//
// The width parameters must match the pipe_pkg constants, since the fields
// are stored through the shared ex_mem_t bundle.
module reg_ex_mem
    import pipe_pkg::*;
#(
    parameter int OPCODE_W = pipe_pkg::OPCODE_W,
    parameter int RD_W     = pipe_pkg::RD_W,
    parameter int DATA_W   = pipe_pkg::DATA_W
) (
    input  logic                clk,
    input  logic                rst,
`ifdef REGEXMEM_HAZARD_EN
    input  logic                stall,
    input  logic                flush,
`endif
    input  logic [OPCODE_W-1:0] OpCode,
    input  logic [RD_W-1:0]     RdOut,
    input  logic [DATA_W-1:0]   BranchResult,
    input  logic [DATA_W-1:0]   AluResult,
    output logic [OPCODE_W-1:0] OpCodeOut,
    output logic [RD_W-1:0]     RdOutOut,
    output logic [DATA_W-1:0]   BranchResultOut,
    output logic [DATA_W-1:0]   AluResultOut
);

    ex_mem_t stage_in_s;
    ex_mem_t stage_out_s;
    logic    clr_s;
    logic    en_s;

    // Bundle the execute-stage fields into one vector.
    always_comb begin
        stage_in_s               = '0;
        stage_in_s.opcode        = OpCode;
        stage_in_s.rd            = RdOut;
        stage_in_s.branch_result = BranchResult;
        stage_in_s.alu_result    = AluResult;
    end

`ifdef REGEXMEM_HAZARD_EN
    // Flush shares the clear path with reset so a bubble is all zeros
    // (OPC_NOP); flush also overrides stall because clear wins in the stage.
    assign clr_s = rst | flush;
    assign en_s  = ~stall;
`else
    assign clr_s = rst;
    assign en_s  = 1'b1;
`endif

    pipe_stage_reg #(
        .WIDTH (EX_MEM_W)
    ) u_stage (
        .clk (clk),
        .clr (clr_s),
        .en  (en_s),
        .d   (stage_in_s),
        .q   (stage_out_s)
    );

    assign OpCodeOut       = stage_out_s.opcode;
    assign RdOutOut        = stage_out_s.rd;
    assign BranchResultOut = stage_out_s.branch_result;
    assign AluResultOut    = stage_out_s.alu_result;

endmodule : reg_ex_mem

// File: tb/tb_reg_ex_mem.sv
// tb_reg_ex_mem: scoreboard bench for reg_ex_mem. The stimulus process
// drives one input set per cycle on the falling edge and, for cycles worth
// checking, queues the hand-computed expected outputs tagged with the edge
// after which they must appear. A monitor samples 1 time unit after each
// rising edge and compares against the queue head for that edge.
// Hazard scenarios run only when REGEXMEM_HAZARD_EN is defined.
module tb_reg_ex_mem;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [4:0]  OpCode;
    logic [8:0]  RdOut;
    logic [31:0] BranchResult;
    logic [31:0] AluResult;
    logic [4:0]  OpCodeOut;
    logic [8:0]  RdOutOut;
    logic [31:0] BranchResultOut;
    logic [31:0] AluResultOut;

    typedef struct {
        int          tag;
        string       name;
        logic [4:0]  op;
        logic [8:0]  rd;
        logic [31:0] br;
        logic [31:0] alu;
    } exp_t;

    exp_t exp_q[$];
    int   edge_cnt;
    int   chk_cnt;
    int   pass_cnt;

    reg_ex_mem dut (
        .clk             (clk),
        .rst             (rst),
`ifdef REGEXMEM_HAZARD_EN
        .stall           (stall),
        .flush           (flush),
`endif
        .OpCode          (OpCode),
        .RdOut           (RdOut),
        .BranchResult    (BranchResult),
        .AluResult       (AluResult),
        .OpCodeOut       (OpCodeOut),
        .RdOutOut        (RdOutOut),
        .BranchResultOut (BranchResultOut),
        .AluResultOut    (AluResultOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_field(input string name, input string field,
                               input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s.%s: got %h, expected %h", name, field, act, exp);
        end
    endtask

    // One cycle of stimulus; when chk is set, queue the expected outputs
    // after the coming rising edge.
    task automatic step(input string name, input logic r, input logic s,
                        input logic f, input logic [4:0] op, input logic [8:0] rd,
                        input logic [31:0] br, input logic [31:0] alu, input bit chk,
                        input logic [4:0] e_op, input logic [8:0] e_rd,
                        input logic [31:0] e_br, input logic [31:0] e_alu);
        exp_t e;
        @(negedge clk);
        rst          = r;
        stall        = s;
        flush        = f;
        OpCode       = op;
        RdOut        = rd;
        BranchResult = br;
        AluResult    = alu;
        if (chk) begin
            e.tag  = edge_cnt + 1;
            e.name = name;
            e.op   = e_op;
            e.rd   = e_rd;
            e.br   = e_br;
            e.alu  = e_alu;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: compare outputs after each edge with the queued expectation.
    initial begin
        edge_cnt = 0;
        forever begin
            @(posedge clk);
            edge_cnt++;
            #1;
            while (exp_q.size() > 0 && exp_q[0].tag <= edge_cnt) begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.tag < edge_cnt) begin
                    chk_cnt++;
                    $display("FAIL %s: expectation for edge %0d not sampled, now edge %0d",
                             e.name, e.tag, edge_cnt);
                end else begin
                    check_field(e.name, "OpCodeOut",       {27'd0, OpCodeOut}, {27'd0, e.op});
                    check_field(e.name, "RdOutOut",        {23'd0, RdOutOut},  {23'd0, e.rd});
                    check_field(e.name, "BranchResultOut", BranchResultOut,    e.br);
                    check_field(e.name, "AluResultOut",    AluResultOut,       e.alu);
                end
            end
        end
    end

    initial begin
        chk_cnt      = 0;
        pass_cnt     = 0;
        rst          = 1'b1;
        stall        = 1'b0;
        flush        = 1'b0;
        OpCode       = 5'd21;
        RdOut        = 9'd300;
        BranchResult = 32'hDEADBEEF;
        AluResult    = 32'h12345678;

        // Reset held for two edges with arbitrary inputs.
        step("reset0", 1'b1, 1'b0, 1'b0, 5'd21, 9'd300, 32'hDEADBEEF, 32'h12345678, 1'b1,
             5'd0, 9'd0, 32'd0, 32'd0);
        step("reset1", 1'b1, 1'b0, 1'b0, 5'd9, 9'd77, 32'hCAFEF00D, 32'h0BADF00D, 1'b1,
             5'd0, 9'd0, 32'd0, 32'd0);

        // Pipeline flow.
        step("flow0", 1'b0, 1'b0, 1'b0, 5'd3, 9'd8, 32'd1, 32'd2, 1'b1,
             5'd3, 9'd8, 32'd1, 32'd2);
        step("flow1", 1'b0, 1'b0, 1'b0, 5'd11, 9'd7, 32'd6, 32'd9, 1'b1,
             5'd11, 9'd7, 32'd6, 32'd9);
        step("flow2", 1'b0, 1'b0, 1'b0, 5'd7, 9'd11, 32'd9, 32'd7, 1'b1,
             5'd7, 9'd11, 32'd9, 32'd7);

`ifdef REGEXMEM_HAZARD_EN
        // Stall: hold 11/7/6/9 for three edges, then load the waiting inputs.
        step("stall_load", 1'b0, 1'b0, 1'b0, 5'd11, 9'd7, 32'd6, 32'd9, 1'b1,
             5'd11, 9'd7, 32'd6, 32'd9);
        for (int i = 0; i < 3; i++) begin
            step("stall_hold", 1'b0, 1'b1, 1'b0, 5'd7, 9'd11, 32'd9, 32'd7, 1'b1,
                 5'd11, 9'd7, 32'd6, 32'd9);
        end
        step("stall_release", 1'b0, 1'b0, 1'b0, 5'd7, 9'd11, 32'd9, 32'd7, 1'b1,
             5'd7, 9'd11, 32'd9, 32'd7);

        // Flush together with stall yields a bubble.
        step("flush_load", 1'b0, 1'b0, 1'b0, 5'd3, 9'd8, 32'd1, 32'd2, 1'b1,
             5'd3, 9'd8, 32'd1, 32'd2);
        step("flush_stall", 1'b0, 1'b1, 1'b1, 5'd11, 9'd7, 32'd6, 32'd9, 1'b1,
             5'd0, 9'd0, 32'd0, 32'd0);
        // Flush alone after a load, and reset combined with flush.
        step("flush_reload", 1'b0, 1'b0, 1'b0, 5'd19, 9'd256, 32'h0000FFFF, 32'hA5A5A5A5, 1'b1,
             5'd19, 9'd256, 32'h0000FFFF, 32'hA5A5A5A5);
        step("flush_only", 1'b0, 1'b0, 1'b1, 5'd1, 9'd1, 32'd1, 32'd1, 1'b1,
             5'd0, 9'd0, 32'd0, 32'd0);
        step("rst_flush", 1'b1, 1'b1, 1'b1, 5'd2, 9'd2, 32'd2, 32'd2, 1'b1,
             5'd0, 9'd0, 32'd0, 32'd0);
        step("stall_zero", 1'b0, 1'b1, 1'b0, 5'd4, 9'd4, 32'd4, 32'd4, 1'b1,
             5'd0, 9'd0, 32'd0, 32'd0);
`endif

        // Reset mid-stream between two valid loads, then all-ones style values.
        step("mid_load", 1'b0, 1'b0, 1'b0, 5'd3, 9'd8, 32'd1, 32'd2, 1'b1,
             5'd3, 9'd8, 32'd1, 32'd2);
        step("mid_rst", 1'b1, 1'b0, 1'b0, 5'd31, 9'd511, 32'hFFFFFFFF, 32'h80000000, 1'b1,
             5'd0, 9'd0, 32'd0, 32'd0);
        step("mid_reload", 1'b0, 1'b0, 1'b0, 5'd31, 9'd511, 32'hFFFFFFFF, 32'h80000000, 1'b1,
             5'd31, 9'd511, 32'hFFFFFFFF, 32'h80000000);
        step("alt_bits", 1'b0, 1'b0, 1'b0, 5'd10, 9'd170, 32'h55555555, 32'hAAAAAAAA, 1'b1,
             5'd10, 9'd170, 32'h55555555, 32'hAAAAAAAA);

        // Drain: give the monitor a bounded window to consume the queue.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        @(negedge clk);
        if (exp_q.size() > 0) begin
            chk_cnt++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_reg_ex_mem
